rom_dl_sched: RTL and testbench

- Sits between data_io and the dual-port SDRAM controller in an arcade core top level.
- Accepts byte-wide ROM download writes and queues them in a small FIFO.
- Routes each byte to SDRAM port1 (CPU ROM region) or port2 (graphics region) with a toggle req/ack handshake, applying the byte-lane mask and rebasing the address.
- Owns the rom_loaded flag and the core reset derived from it, replacing ad-hoc free-running req toggling.

---
 rtl/rom_dl_pkg.sv | 13 +
 rtl/rom_dl_fifo.sv | 49 ++++
 rtl/rom_dl_sched.sv | 142 ++++++++++++++
 tb/tb_rom_dl_sched.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_dl_pkg.sv
// rtl/rom_dl_pkg.sv - shared types and widths for the ROM download scheduler
package rom_dl_pkg;
   localparam int ADDR_W  = 25;
   localparam int WADDR_W = 23;

   typedef struct packed {
      logic              sel;
      logic [ADDR_W-1:0] addr;
      logic [7:0]        data;
   } dl_entry_t;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} sched_state_t;
endpackage

// File: rtl/rom_dl_fifo.sv
// rtl/rom_dl_fifo.sv - synchronous FIFO of download entries
// A push on a full FIFO is honoured only when a pop happens in the same cycle.
import rom_dl_pkg::*;

module rom_dl_fifo #(
   parameter int DEPTH = 4
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      push,
   input  logic      pop,
   input  dl_entry_t din,
   output dl_entry_t dout,
   output logic      full,
   output logic      empty
);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   dl_entry_t   mem_q [DEPTH];
   logic [IW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic        do_push, do_pop;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[IW] != rd_ptr_q[IW]) && (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;
   assign dout    = mem_q[rd_ptr_q[IW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + (IW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (IW+1)'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[IW-1:0]] <= din;
   end
endmodule

// File: rtl/rom_dl_sched.sv
// rtl/rom_dl_sched.sv - queues ROM download bytes and issues them to SDRAM port1/port2
// Optional checksum output is enabled with ROM_DL_CHECKSUM_EN.
import rom_dl_pkg::*;

module rom_dl_sched #(
   parameter logic [ADDR_W-1:0] GFX_BASE   = 25'h10000,
   parameter logic [7:0]        ROM_INDEX  = 8'd0,
   parameter int                FIFO_DEPTH = 4
) (
   input  logic               clk_sys,
   input  logic               reset,
   input  logic               ioctl_downl,
   input  logic [7:0]         ioctl_index,
   input  logic               ioctl_wr,
   input  logic [ADDR_W-1:0]  ioctl_addr,
   input  logic [7:0]         ioctl_dout,
   input  logic               user_reset,
   output logic               port1_req,
   input  logic               port1_ack,
   output logic [WADDR_W-1:0] port1_a,
   output logic [1:0]         port1_ds,
   output logic [15:0]        port1_d,
   output logic               port2_req,
   input  logic               port2_ack,
   output logic [WADDR_W-1:0] port2_a,
   output logic [1:0]         port2_ds,
   output logic [15:0]        port2_d,
   output logic               port_we,
   output logic               dl_busy,
   output logic               ovf,
   output logic               rom_loaded,
   output logic               core_reset
`ifdef ROM_DL_CHECKSUM_EN
   ,
   output logic [15:0]        checksum
`endif
);
   sched_state_t       state_q, state_d;
   dl_entry_t          in_entry, head;
   logic               wr_q, downl_q, seen_q, seen_d;
   logic               accept, downl_rise, pop, fifo_full, fifo_empty;
   logic               p1_req_q, p1_req_d, p2_req_q, p2_req_d, sel_q, sel_d;
   logic [WADDR_W-1:0] p1_a_q, p1_a_d, p2_a_q, p2_a_d;
   logic [1:0]         p1_ds_q, p1_ds_d, p2_ds_q, p2_ds_d;
   logic [15:0]        p1_d_q, p1_d_d, p2_d_q, p2_d_d;
   logic               ovf_q, ovf_d, loaded_q, loaded_d, core_reset_q, core_reset_d;
   logic               port_we_q, port_we_d, busy;
`ifdef ROM_DL_CHECKSUM_EN
   logic [15:0]        csum_q, csum_d;
   assign checksum = csum_q;
`endif

   assign accept       = ioctl_wr && !wr_q && ioctl_downl && (ioctl_index == ROM_INDEX);
   assign downl_rise   = ioctl_downl && !downl_q;
   assign in_entry.sel = (ioctl_addr >= GFX_BASE);
   assign in_entry.addr = in_entry.sel ? (ioctl_addr - GFX_BASE) : ioctl_addr;
   assign in_entry.data = ioctl_dout;
   assign busy         = !fifo_empty || (state_q != IDLE);

   rom_dl_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk_sys), .rst(reset), .push(accept), .pop(pop), .din(in_entry),
      .dout(head), .full(fifo_full), .empty(fifo_empty)
   );

   always_comb begin
      state_d  = state_q;
      pop      = 1'b0;
      sel_d    = sel_q;
      p1_req_d = p1_req_q;  p1_a_d = p1_a_q;  p1_ds_d = p1_ds_q;  p1_d_d = p1_d_q;
      p2_req_d = p2_req_q;  p2_a_d = p2_a_q;  p2_ds_d = p2_ds_q;  p2_d_d = p2_d_q;
      case (state_q)
         // Entering ISSUE on the accept itself gives the two-cycle accept-to-req latency.
         IDLE: if (!fifo_empty || accept) state_d = ISSUE;
         ISSUE: begin
            pop   = 1'b1;
            sel_d = head.sel;
            if (head.sel) begin
               p2_req_d = ~p2_req_q;
               p2_a_d   = head.addr[WADDR_W:1];
               p2_ds_d  = {head.addr[0], ~head.addr[0]};
               p2_d_d   = {head.data, head.data};
            end else begin
               p1_req_d = ~p1_req_q;
               p1_a_d   = head.addr[WADDR_W:1];
               p1_ds_d  = {head.addr[0], ~head.addr[0]};
               p1_d_d   = {head.data, head.data};
            end
            state_d = WAIT;
         end
         WAIT: if (sel_q ? (port2_ack == p2_req_q) : (port1_ack == p1_req_q)) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      seen_d       = seen_q || ioctl_downl;
      ovf_d        = downl_rise ? 1'b0 : (ovf_q || (accept && fifo_full && !pop));
      loaded_d     = downl_rise ? 1'b0 :
                     (loaded_q || (seen_q && !ioctl_downl && fifo_empty && state_q == IDLE));
      core_reset_d = user_reset || !loaded_q || ioctl_downl;
      port_we_d    = ioctl_downl || busy;
`ifdef ROM_DL_CHECKSUM_EN
      csum_d = csum_q;
      if (downl_rise)           csum_d = '0;
      else if (state_q == ISSUE) csum_d = csum_q + {8'd0, head.data};
`endif
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;  wr_q <= 1'b0;  downl_q <= 1'b0;  seen_q <= 1'b0;  sel_q <= 1'b0;
         p1_req_q <= 1'b0;  p1_a_q <= '0;  p1_ds_q <= '0;  p1_d_q <= '0;
         p2_req_q <= 1'b0;  p2_a_q <= '0;  p2_ds_q <= '0;  p2_d_q <= '0;
         ovf_q <= 1'b0;  loaded_q <= 1'b0;  core_reset_q <= 1'b1;  port_we_q <= 1'b0;
`ifdef ROM_DL_CHECKSUM_EN
         csum_q <= '0;
`endif
      end else begin
         state_q <= state_d;  wr_q <= ioctl_wr;  downl_q <= ioctl_downl;  seen_q <= seen_d;
         sel_q <= sel_d;
         p1_req_q <= p1_req_d;  p1_a_q <= p1_a_d;  p1_ds_q <= p1_ds_d;  p1_d_q <= p1_d_d;
         p2_req_q <= p2_req_d;  p2_a_q <= p2_a_d;  p2_ds_q <= p2_ds_d;  p2_d_q <= p2_d_d;
         ovf_q <= ovf_d;  loaded_q <= loaded_d;  core_reset_q <= core_reset_d;
         port_we_q <= port_we_d;
`ifdef ROM_DL_CHECKSUM_EN
         csum_q <= csum_d;
`endif
      end
   end

   assign port1_req  = p1_req_q;
   assign port1_a    = p1_a_q;
   assign port1_ds   = p1_ds_q;
   assign port1_d    = p1_d_q;
   assign port2_req  = p2_req_q;
   assign port2_a    = p2_a_q;
   assign port2_ds   = p2_ds_q;
   assign port2_d    = p2_d_q;
   assign port_we    = port_we_q;
   assign dl_busy    = busy;
   assign ovf        = ovf_q;
   assign rom_loaded = loaded_q;
   assign core_reset = core_reset_q;
endmodule

// File: tb/tb_rom_dl_sched.sv
// tb/tb_rom_dl_sched.sv - scoreboard bench for rom_dl_sched
module tb_rom_dl_sched;
   typedef struct {
      logic        port2;
      logic [22:0] a;
      logic [1:0]  ds;
      logic [15:0] d;
   } exp_t;

   logic        clk_sys = 1'b0, reset = 1'b1;
   logic        ioctl_downl = 1'b0, ioctl_wr = 1'b0, user_reset = 1'b0;
   logic [7:0]  ioctl_index = 8'd0, ioctl_dout = 8'd0;
   logic [24:0] ioctl_addr = '0;
   logic        port1_req, port1_ack = 1'b0, port2_req, port2_ack = 1'b0;
   logic [22:0] port1_a, port2_a;
   logic [1:0]  port1_ds, port2_ds;
   logic [15:0] port1_d, port2_d;
   logic        port_we, dl_busy, ovf, rom_loaded, core_reset;
   logic        hold = 1'b0;
   int          checks = 0, passes = 0;
   exp_t        exp_q[$];
`ifdef ROM_DL_CHECKSUM_EN
   logic [15:0] checksum;
`endif

   always #5 clk_sys = ~clk_sys;

   rom_dl_sched dut (
      .clk_sys(clk_sys), .reset(reset), .ioctl_downl(ioctl_downl), .ioctl_index(ioctl_index),
      .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
      .user_reset(user_reset),
      .port1_req(port1_req), .port1_ack(port1_ack), .port1_a(port1_a), .port1_ds(port1_ds),
      .port1_d(port1_d),
      .port2_req(port2_req), .port2_ack(port2_ack), .port2_a(port2_a), .port2_ds(port2_ds),
      .port2_d(port2_d),
      .port_we(port_we), .dl_busy(dl_busy), .ovf(ovf), .rom_loaded(rom_loaded),
      .core_reset(core_reset)
`ifdef ROM_DL_CHECKSUM_EN
      , .checksum(checksum)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, req);
   endtask

   task automatic expect_tx(input logic p2, input logic [22:0] a, input logic [1:0] ds,
                            input logic [7:0] data);
      exp_t e;
      e.port2 = p2;  e.a = a;  e.ds = ds;  e.d = {data, data};
      exp_q.push_back(e);
   endtask

   task automatic strobe(input logic [24:0] addr, input logic [7:0] data, input logic [7:0] idx);
      @(negedge clk_sys);
      ioctl_addr = addr;  ioctl_dout = data;  ioctl_index = idx;  ioctl_wr = 1'b1;
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((dl_busy || exp_q.size() != 0) && n < 200) begin
         @(negedge clk_sys);
         n++;
      end
      check({name, " drained"}, exp_q.size(), 0);
      check({name, " not busy"}, dl_busy, 0);
   endtask

   task automatic wait_loaded(input string name);
      int n = 0;
      while (!rom_loaded && n < 200) begin
         @(negedge clk_sys);
         n++;
      end
      check({name, " rom_loaded"}, rom_loaded, 1);
   endtask

   // SDRAM model: returns ack one negedge after the req toggle unless held off.
   initial begin
      forever begin
         @(negedge clk_sys);
         if (reset) begin
            port1_ack = 1'b0;  port2_ack = 1'b0;
         end else if (!hold) begin
            port1_ack = port1_req;  port2_ack = port2_req;
         end
      end
   end

   // Monitor: every req toggle pops one expected transaction.
   initial begin
      logic p1_prev = 1'b0, p2_prev = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk_sys);
         if (reset) begin
            p1_prev = 1'b0;  p2_prev = 1'b0;
         end else begin
            if (port1_req != p1_prev) begin
               p1_prev = port1_req;
               if (exp_q.size() == 0) check("port1 unexpected req", 1, 0);
               else begin
                  e = exp_q.pop_front();
                  check("port1 selected", 1'b0, e.port2);
                  check("port1_a", port1_a, e.a);
                  check("port1_ds", port1_ds, e.ds);
                  check("port1_d", port1_d, e.d);
               end
            end
            if (port2_req != p2_prev) begin
               p2_prev = port2_req;
               if (exp_q.size() == 0) check("port2 unexpected req", 1, 0);
               else begin
                  e = exp_q.pop_front();
                  check("port2 selected", 1'b1, e.port2);
                  check("port2_a", port2_a, e.a);
                  check("port2_ds", port2_ds, e.ds);
                  check("port2_d", port2_d, e.d);
               end
            end
         end
      end
   end

   logic [24:0] v_addr [6] = '{25'h00010, 25'h10001, 25'h00007, 25'h1FFFE, 25'h0FFFF, 25'h10000};
   logic [7:0]  v_data [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
   logic        v_p2   [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
   logic [22:0] v_a    [6] = '{23'h8, 23'h0, 23'h3, 23'h7FFF, 23'h7FFF, 23'h0};
   logic [1:0]  v_ds   [6] = '{2'b01, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01};

   initial begin
      logic p1_saved, p2_saved;
      repeat (3) @(negedge clk_sys);
      check("reset port1_req", port1_req, 0);
      check("reset port2_req", port2_req, 0);
      check("reset core_reset", core_reset, 1);
      check("reset rom_loaded", rom_loaded, 0);
      check("reset dl_busy", dl_busy, 0);
      check("reset port_we", port_we, 0);
      reset = 1'b0;
      @(negedge clk_sys);
      ioctl_downl = 1'b1;

      // CPU region byte with exact accept-to-req latency
      expect_tx(1'b0, 23'd1, 2'b10, 8'h5A);
      @(negedge clk_sys);
      ioctl_addr = 25'h00003;  ioctl_dout = 8'h5A;  ioctl_index = 8'd0;  ioctl_wr = 1'b1;
      @(posedge clk_sys); #1;
      check("latency N+1 port1_req", port1_req, 0);
      @(posedge clk_sys); #1;
      check("latency N+2 port1_req", port1_req, 1);
      check("latency port2_req idle", port2_req, 0);
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      wait_idle("cpu byte");

      // Graphics region byte, rebased
      expect_tx(1'b1, 23'd2, 2'b01, 8'hC3);
      strobe(25'h10004, 8'hC3, 8'd0);
      wait_idle("gfx byte");

      // Wrong download index is ignored
      p1_saved = port1_req;  p2_saved = port2_req;
      strobe(25'h00005, 8'h99, 8'd1);
      repeat (4) @(negedge clk_sys);
      check("bad index busy", dl_busy, 0);
      check("bad index port1_req", port1_req, p1_saved);
      check("bad index port2_req", port2_req, p2_saved);

      // Ack held: one byte in WAIT, four queued, the sixth dropped
      hold = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i < 5) expect_tx(v_p2[i], v_a[i], v_ds[i], v_data[i]);
         strobe(v_addr[i], v_data[i], 8'd0);
      end
      @(negedge clk_sys);
      check("overflow ovf", ovf, 1);
      check("overflow busy", dl_busy, 1);
      check("overflow port_we", port_we, 1);
      hold = 1'b0;
      wait_idle("overflow");
      check("ovf sticky", ovf, 1);

      // New download clears ovf; end download with two entries pending
      ioctl_downl = 1'b0;
      @(negedge clk_sys);
      ioctl_downl = 1'b1;
      @(negedge clk_sys);
      check("ovf cleared on downl rise", ovf, 0);
      check("rom_loaded cleared on downl rise", rom_loaded, 0);
      hold = 1'b1;
      expect_tx(1'b1, 23'd0, 2'b01, 8'h77);
      strobe(25'h10000, 8'h77, 8'd0);
      expect_tx(1'b0, 23'd1, 2'b01, 8'h88);
      strobe(25'h00002, 8'h88, 8'd0);
      ioctl_downl = 1'b0;
      repeat (4) @(negedge clk_sys);
      check("pending rom_loaded", rom_loaded, 0);
      check("pending core_reset", core_reset, 1);
      hold = 1'b0;
      wait_loaded("end download");
      check("end download drained", exp_q.size(), 0);
      check("core_reset before fall", core_reset, 1);
      @(negedge clk_sys);
      check("core_reset falls", core_reset, 0);
      user_reset = 1'b1;
      @(negedge clk_sys);
      check("user_reset forces core_reset", core_reset, 1);
      user_reset = 1'b0;

      // Reset while waiting for an ack
      ioctl_downl = 1'b1;
      hold = 1'b1;
      expect_tx(1'b0, 23'h10, 2'b01, 8'hAB);
      strobe(25'h00020, 8'hAB, 8'd0);
      repeat (3) @(negedge clk_sys);
      check("pre-reset busy", dl_busy, 1);
      reset = 1'b1;
      exp_q.delete();
      @(posedge clk_sys); #1;
      check("mid reset port1_req", port1_req, 0);
      check("mid reset port1_a", port1_a, 0);
      check("mid reset port1_ds", port1_ds, 0);
      check("mid reset port1_d", port1_d, 0);
      check("mid reset port2_req", port2_req, 0);
      check("mid reset dl_busy", dl_busy, 0);
      check("mid reset port_we", port_we, 0);
      check("mid reset ovf", ovf, 0);
      check("mid reset rom_loaded", rom_loaded, 0);
      check("mid reset core_reset", core_reset, 1);
      @(negedge clk_sys);
      hold = 1'b0;
      ioctl_downl = 1'b0;
      @(negedge clk_sys);
      reset = 1'b0;
      repeat (2) @(negedge clk_sys);

`ifdef ROM_DL_CHECKSUM_EN
      ioctl_downl = 1'b1;
      @(negedge clk_sys);
      expect_tx(1'b0, 23'd0, 2'b01, 8'hFF);
      strobe(25'h00000, 8'hFF, 8'd0);
      expect_tx(1'b0, 23'd0, 2'b10, 8'hFF);
      strobe(25'h00001, 8'hFF, 8'd0);
      expect_tx(1'b0, 23'd1, 2'b01, 8'h02);
      strobe(25'h00002, 8'h02, 8'd0);
      ioctl_downl = 1'b0;
      wait_loaded("checksum");
      check("checksum", checksum, 16'h0200);
`endif

      repeat (4) @(negedge clk_sys);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
